// File: rtl/gpio_ctrl.sv
// gpio_ctrl: CPU-bus register front end for the 32-pin GPIO block.
// Holds shadow direction/output words, issues one-cycle load strobes to the
// pin block, synchronises the pin input word, detects per-pin edges and
// raises a maskable level interrupt.
module gpio_ctrl (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [2:0]  i_addr,
  input  logic        i_wr,
  input  logic        i_rd,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_rvalid,
  output logic [31:0] o_DDIR,
  output logic        o_WER,
  output logic [31:0] o_DOUT,
  output logic        o_WEO,
  input  logic [31:0] i_DIN,
  output logic        o_irq
);

  localparam int unsigned NPIN = 32;
  localparam int unsigned AW   = 3;
  localparam int unsigned CW   = 2;

  localparam logic [AW-1:0] A_DIR     = 3'd0;
  localparam logic [AW-1:0] A_OUT     = 3'd1;
  localparam logic [AW-1:0] A_OUT_SET = 3'd2;
  localparam logic [AW-1:0] A_OUT_CLR = 3'd3;
  localparam logic [AW-1:0] A_IN      = 3'd4;
  localparam logic [AW-1:0] A_STATUS  = 3'd5;
  localparam logic [AW-1:0] A_MASK    = 3'd6;
  localparam logic [AW-1:0] A_ESEL    = 3'd7;

  localparam logic [CW-1:0] ARM_CNT = 2'd2;

  // Shadow and status registers
  logic [NPIN-1:0] r_dir;
  logic [NPIN-1:0] r_out;
  logic [NPIN-1:0] r_mask;
  logic [NPIN-1:0] r_esel;
  logic [NPIN-1:0] r_status;
  logic [NPIN-1:0] r_in_s;
  logic [NPIN-1:0] r_in_p;
  logic [CW-1:0]   r_cnt;
  logic            r_wer;
  logic            r_weo;
  logic            r_rvalid;
  logic [NPIN-1:0] r_rdata;
  logic            r_irq;

  // Decoded bus actions and edge logic
  logic            w_wr_dir;
  logic            w_wr_out;
  logic            w_wr_set;
  logic            w_wr_clr;
  logic            w_wr_status;
  logic            w_wr_mask;
  logic            w_wr_esel;
  logic            w_rd_ok;
  logic            w_armed;
  logic [NPIN-1:0] w_rise;
  logic [NPIN-1:0] w_fall;
  logic [NPIN-1:0] w_event;
  logic [NPIN-1:0] w_clr;
  logic [NPIN-1:0] w_status_nxt;
  logic [NPIN-1:0] w_rd_mux;

  assign w_wr_dir    = i_wr && (i_addr == A_DIR);
  assign w_wr_out    = i_wr && (i_addr == A_OUT);
  assign w_wr_set    = i_wr && (i_addr == A_OUT_SET);
  assign w_wr_clr    = i_wr && (i_addr == A_OUT_CLR);
  assign w_wr_status = i_wr && (i_addr == A_STATUS);
  assign w_wr_mask   = i_wr && (i_addr == A_MASK);
  assign w_wr_esel   = i_wr && (i_addr == A_ESEL);

  // A read colliding with a write is dropped; the write wins
  assign w_rd_ok = i_rd && !i_wr;

  // Edges are ignored until the sync stages hold real samples
  assign w_armed = (r_cnt == ARM_CNT);

  assign w_rise  = r_in_s & ~r_in_p;
  assign w_fall  = r_in_p & ~r_in_s;
  assign w_event = r_dir & {NPIN{w_armed}} & ((r_esel & w_fall) | (~r_esel & w_rise));

  // New events win over a same-cycle W1C on the same bit
  assign w_clr        = w_wr_status ? i_wdata : '0;
  assign w_status_nxt = (r_status & ~w_clr) | w_event;

  assign o_DDIR   = r_dir;
  assign o_DOUT   = r_out;
  assign o_WER    = r_wer;
  assign o_WEO    = r_weo;
  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
  assign o_irq    = r_irq;

  // Read-data mux over pre-update register values
  always_comb begin
    w_rd_mux = '0;
    case (i_addr)
      A_DIR:    w_rd_mux = r_dir;
      A_OUT:    w_rd_mux = r_out;
      A_IN:     w_rd_mux = r_in_s;
      A_STATUS: w_rd_mux = r_status;
      A_MASK:   w_rd_mux = r_mask;
      A_ESEL:   w_rd_mux = r_esel;
      default:  w_rd_mux = '0;
    endcase
  end

  // Shadow registers and their pin-block load strobes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dir  <= '0;
      r_out  <= '0;
      r_mask <= '0;
      r_esel <= '0;
      r_wer  <= 1'b0;
      r_weo  <= 1'b0;
    end else begin
      r_wer <= w_wr_dir;
      r_weo <= w_wr_out || w_wr_set || w_wr_clr;
      if (w_wr_dir)  r_dir  <= i_wdata;
      if (w_wr_out)  r_out  <= i_wdata;
      if (w_wr_set)  r_out  <= r_out | i_wdata;
      if (w_wr_clr)  r_out  <= r_out & ~i_wdata;
      if (w_wr_mask) r_mask <= i_wdata;
      if (w_wr_esel) r_esel <= i_wdata;
    end
  end

  // Input synchroniser and post-reset arming counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_s <= '0;
      r_in_p <= '0;
      r_cnt  <= '0;
    end else begin
      r_in_s <= i_DIN;
      r_in_p <= r_in_s;
      if (r_cnt != ARM_CNT) r_cnt <= r_cnt + CW'(1);
    end
  end

  // Edge status flags and the registered interrupt level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_status <= w_status_nxt;
      r_irq    <= |(w_status_nxt & r_mask);
    end
  end

  // Read response: one-cycle strobe, data forced to zero when idle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_rd_ok;
      r_rdata  <= w_rd_ok ? w_rd_mux : '0;
    end
  end

endmodule
